// File: rtl/bcd_counter_decoder_if.sv
// bcd_counter_decoder_if: control inputs and registered count/decode outputs of the BCD counter.
interface bcd_counter_decoder_if #(parameter int DIGITS = 2);
  logic                 en;
  logic                 up_dn;
  logic                 load;
  logic [4*DIGITS-1:0]  load_val;
  logic [4*DIGITS-1:0]  count;
  logic [10*DIGITS-1:0] dec_out;
  logic                 carry_out;
  logic                 invalid;
  modport master (output en, up_dn, load, load_val, input count, dec_out, carry_out, invalid);
  modport slave  (input en, up_dn, load, load_val, output count, dec_out, carry_out, invalid);
endinterface

// File: rtl/bcd_counter_decoder.sv
// bcd_counter_decoder: multi-digit BCD up/down counter with registered per-digit decimal decoders.
module bcd_counter_decoder #(
  parameter int DIGITS     = 2,
  parameter bit ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  bcd_counter_decoder_if.slave bus
);
  logic [4*DIGITS-1:0]  count_q, count_d, step;
  logic [10*DIGITS-1:0] dec_out_q, dec_out_d;
  logic                 carry_out_q, carry_out_d, invalid_q, invalid_d, rip;
  logic [3:0]           dg;
  always_comb begin
    step = count_q;
    rip  = 1'b1;
    dg   = '0;
    // rip stays high only while every digit so far wrapped; a non-BCD digit is cleared and stops it
    for (int i = 0; i < DIGITS; i++) begin
      dg = count_q[4*i +: 4];
      if (rip) begin
        step[4*i +: 4] = dg > 4'd9 ? 4'd0 :
                         bus.up_dn ? (dg == 4'd9 ? 4'd0 : dg + 4'd1) :
                                     (dg == 4'd0 ? 4'd9 : dg - 4'd1);
        rip = dg == (bus.up_dn ? 4'd9 : 4'd0);
      end
    end
    count_d     = bus.load ? bus.load_val : bus.en ? step : count_q;
    carry_out_d = !bus.load && bus.en && rip;
    invalid_d   = 1'b0;
    dec_out_d   = '0;
    // decode the next count so outputs land on the same edge as count
    for (int i = 0; i < DIGITS; i++) begin
      invalid_d = invalid_d | (count_d[4*i +: 4] > 4'd9);
      for (int n = 0; n < 10; n++)
        dec_out_d[10*i+n] = ACTIVE_LOW ^ (count_d[4*i +: 4] == 4'(n));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      dec_out_q   <= {DIGITS{ACTIVE_LOW ? 10'h3fe : 10'h001}};
      carry_out_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      dec_out_q   <= dec_out_d;
      carry_out_q <= carry_out_d;
      invalid_q   <= invalid_d;
    end
  end
  assign bus.count     = count_q;
  assign bus.dec_out   = dec_out_q;
  assign bus.carry_out = carry_out_q;
  assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_bcd_counter_decoder.sv
// tb_bcd_counter_decoder: scoreboard bench for a 2-digit active-low and a 1-digit active-high counter.
module tb_bcd_counter_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_decoder_if #(.DIGITS(2)) ba ();
  bcd_counter_decoder_if #(.DIGITS(1)) bb ();
  bcd_counter_decoder #(.DIGITS(2), .ACTIVE_LOW(1)) u_a (.clk(clk), .rst(rst), .bus(ba.slave));
  bcd_counter_decoder #(.DIGITS(1), .ACTIVE_LOW(0)) u_b (.clk(clk), .rst(rst), .bus(bb.slave));

  typedef struct {
    logic [31:0] c;
    logic [79:0] d;
    logic        cy;
    logic        inv;
  } exp_t;

  exp_t qa[$], qb[$];
  int vectors = 0, miss = 0;
  logic        r_i = 1'b1, la = 0, ea = 0, ua = 0, lb = 0, eb = 0, ub = 0;
  logic [7:0]  lva = '0;
  logic [3:0]  lvb = '0;
  logic [31:0] ma = '0, mb = '0;
  logic        done = 1'b0;

  // Reference: plain decimal arithmetic when all digits are BCD, digit rules otherwise.
  function automatic void mdl(input int nd, input logic [31:0] c, input logic r, input logic ld,
                              input logic [31:0] lv, input logic e, input logic u,
                              output logic [31:0] n, output logic cy);
    int v, lim;
    bit ok, go;
    logic [3:0] g;
    n = c; cy = 1'b0;
    if (r) n = '0;
    else if (ld) n = lv;
    else if (e) begin
      ok = 1; v = 0; lim = 1;
      for (int d = nd - 1; d >= 0; d--) begin
        if (c[4*d +: 4] > 9) ok = 0;
        v = v * 10 + int'(c[4*d +: 4]);
        lim = lim * 10;
      end
      if (ok) begin
        cy = u ? (v == lim - 1) : (v == 0);
        v = u ? (v + 1) % lim : (v + lim - 1) % lim;
        for (int d = 0; d < nd; d++) begin
          n[4*d +: 4] = 4'(v % 10);
          v = v / 10;
        end
      end else begin
        go = 1;
        for (int d = 0; d < nd; d++) if (go) begin
          g = c[4*d +: 4];
          if (g > 9) begin g = 0; go = 0; end
          else if (u) begin go = (g == 9); g = go ? 4'd0 : g + 4'd1; end
          else begin go = (g == 0); g = go ? 4'd9 : g - 4'd1; end
          n[4*d +: 4] = g;
        end
      end
    end
  endfunction

  function automatic exp_t mk(input int nd, input bit al, input logic [31:0] c, input logic cy);
    exp_t e;
    int v;
    e.c = c; e.cy = cy; e.inv = 1'b0; e.d = '0;
    for (int d = 0; d < nd; d++) begin
      v = int'(c[4*d +: 4]);
      if (v > 9) e.inv = 1'b1;
      for (int k = 0; k < 10; k++)
        e.d[10*d+k] = (v == k) ? !al : al;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [31:0] n;
    logic cy;
    @(negedge clk);
    rst = r_i;
    ba.load = la; ba.load_val = lva; ba.en = ea; ba.up_dn = ua;
    bb.load = lb; bb.load_val = lvb; bb.en = eb; bb.up_dn = ub;
    mdl(2, ma, r_i, la, {24'd0, lva}, ea, ua, n, cy);
    ma = n; qa.push_back(mk(2, 1, n, cy));
    mdl(1, mb, r_i, lb, {28'd0, lvb}, eb, ub, n, cy);
    mb = n; qb.push_back(mk(1, 0, n, cy));
    @(posedge clk);
    #2;
  endtask

  task automatic ld_a(input logic [7:0] v);
    la = 1; lva = v; ea = 0; tick(); la = 0;
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a.count", 80'(ba.count), 80'(e.c[7:0]));
      chk("a.dec_out", 80'(ba.dec_out), 80'(e.d[19:0]));
      chk("a.carry_out", 80'(ba.carry_out), 80'(e.cy));
      chk("a.invalid", 80'(ba.invalid), 80'(e.inv));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b.count", 80'(bb.count), 80'(e.c[3:0]));
      chk("b.dec_out", 80'(bb.dec_out), 80'(e.d[9:0]));
      chk("b.carry_out", 80'(bb.carry_out), 80'(e.cy));
      chk("b.invalid", 80'(bb.invalid), 80'(e.inv));
    end
  end

  initial begin
    rst = 1'b1;
    ba.en = 0; ba.up_dn = 0; ba.load = 0; ba.load_val = '0;
    bb.en = 0; bb.up_dn = 0; bb.load = 0; bb.load_val = '0;
    r_i = 1; tick(); tick();
    r_i = 0; tick(); tick();
    chk("reset.count", 80'(ba.count), 80'h00);
    chk("reset.dec_out", 80'(ba.dec_out), 80'(20'b1111111110_1111111110));
    chk("reset.carry", 80'(ba.carry_out), 80'd0);
    chk("reset.invalid", 80'(ba.invalid), 80'd0);
    // up wrap
    ld_a(8'h98);
    ea = 1; ua = 1;
    tick(); chk("up.99", 80'(ba.count), 80'h99); chk("up.99.carry", 80'(ba.carry_out), 80'd0);
    tick(); chk("up.00", 80'(ba.count), 80'h00); chk("up.00.carry", 80'(ba.carry_out), 80'd1);
    tick(); chk("up.01", 80'(ba.count), 80'h01); chk("up.01.carry", 80'(ba.carry_out), 80'd0);
    chk("up.01.dec0", 80'(ba.dec_out[9:0]), 80'(10'b1111111101));
    // down wrap
    ld_a(8'h01);
    ea = 1; ua = 0;
    tick(); chk("dn.00", 80'(ba.count), 80'h00); chk("dn.00.carry", 80'(ba.carry_out), 80'd0);
    tick(); chk("dn.99", 80'(ba.count), 80'h99); chk("dn.99.carry", 80'(ba.carry_out), 80'd1);
    chk("dn.99.dec1", 80'(ba.dec_out[19:10]), 80'(10'b0111111111));
    tick(); chk("dn.98", 80'(ba.count), 80'h98); chk("dn.98.carry", 80'(ba.carry_out), 80'd0);
    // invalid digit
    ld_a(8'h3c);
    chk("inv.flag", 80'(ba.invalid), 80'd1);
    chk("inv.dec0", 80'(ba.dec_out[9:0]), 80'(10'h3ff));
    ea = 1; ua = 1; tick();
    chk("inv.step", 80'(ba.count), 80'h30);
    chk("inv.clear", 80'(ba.invalid), 80'd0);
    chk("inv.carry", 80'(ba.carry_out), 80'd0);
    // priority
    ld_a(8'h45);
    la = 1; lva = 8'h77; ea = 1; ua = 1; tick();
    chk("prio.load", 80'(ba.count), 80'h77);
    chk("prio.carry", 80'(ba.carry_out), 80'd0);
    la = 0; r_i = 1; tick(); r_i = 0;
    chk("prio.rst", 80'(ba.count), 80'h00);
    // direction toggling
    ld_a(8'h50);
    ea = 1;
    ua = 1; tick(); chk("dir.51a", 80'(ba.count), 80'h51);
    ua = 0; tick(); chk("dir.50a", 80'(ba.count), 80'h50);
    ua = 1; tick(); chk("dir.51b", 80'(ba.count), 80'h51);
    ua = 0; tick(); chk("dir.50b", 80'(ba.count), 80'h50);
    ea = 0;
    // single digit, active-high
    lb = 1; lvb = 4'd0; tick(); lb = 0;
    eb = 1; ub = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b.onehot", 80'($countones(bb.dec_out)), 80'd1);
      chk("b.seq", 80'(bb.count), 80'(i % 10));
      chk("b.wrap", 80'(bb.carry_out), 80'(i % 10 == 0));
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_i = ($urandom_range(0, 49) == 0);
      la = ($urandom_range(0, 7) == 0); lva = 8'($urandom);
      if ($urandom_range(0, 3) != 0) lva = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ea = ($urandom_range(0, 3) != 0); ua = 1'($urandom);
      lb = ($urandom_range(0, 7) == 0); lvb = 4'($urandom);
      eb = ($urandom_range(0, 3) != 0); ub = 1'($urandom);
      tick();
    end
    r_i = 0; la = 0; ea = 0; lb = 0; eb = 0;
    @(posedge clk); #2;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miss++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
